nios_security_duty_capture: RTL and testbench

Avalon-MM slave peripheral that measures an external PWM input (e.g. an RC receiver channel or a servo feedback line) and exposes the last complete high time and period, in clk cycles, to the Nios II processor. It is the capture counterpart of the duty-cycle output register: that block writes a duty value out to a PWM generator, and this block reads a duty cycle back in. It sits on the same system interconnect as the other PIO-style slaves and raises an optional interrupt when a new measurement is available or the input stalls.

---
 rtl/nios_security_duty_capture.sv | 235 +++++++++++++++++++++++
 tb/tb_nios_security_duty_capture.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_security_duty_capture.sv
// nios_security_duty_capture: Avalon-MM slave that measures an external PWM input.
// Reports the high time and period of the last complete PWM cycle (in clk cycles), flags
// a timeout when the input stalls, and raises a registered level interrupt.
module nios_security_duty_capture #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd2000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   input  logic        in_port,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam logic [31:0] TimeoutVal = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] CntMax     = 32'hFFFF_FFFF;

   localparam logic [1:0] AddrHighTime = 2'd0;
   localparam logic [1:0] AddrPeriod   = 2'd1;
   localparam logic [1:0] AddrStatus   = 2'd2;
   localparam logic [1:0] AddrControl  = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StWaitRise,
      StHigh,
      StLow
   } state_t;

   // Input conditioning
   logic s1_q, s2_q, s3_q;
   logic rise, fall;

   // Measurement datapath
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] hi_pend_q, hi_pend_d;
   logic [31:0] high_time_q, high_time_d;
   logic [31:0] period_q, period_d;

   // Status and control
   logic valid_q, valid_d;
   logic timeout_q, timeout_d;
   logic overrun_q, overrun_d;
   logic en_q, en_d;
   logic irq_en_q, irq_en_d;
   logic irq_q;

   // FSM
   state_t state_q, state_d;
   logic   active;
   logic   commit;
   logic   timeout_evt;

   // Bus decode
   logic wr_status, wr_control;

   assign wr_status  = chipselect & ~write_n & (address == AddrStatus);
   assign wr_control = chipselect & ~write_n & (address == AddrControl);

   // Two-flop synchronizer plus one history flop for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= in_port;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;

   // Measuring only while enabled and out of IDLE; this also discards state on disable.
   assign active = en_q && (state_q != StIdle);

   // Next-state logic; a pending timeout overrides any ordinary transition except a rise.
   always_comb begin
      state_d     = state_q;
      commit      = 1'b0;
      timeout_evt = 1'b0;
      if (!en_q) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:     state_d = StWaitRise;
            StWaitRise: if (rise) state_d = StHigh;
            StHigh:     if (fall) state_d = StLow;
            StLow: begin
               if (rise) begin
                  commit  = 1'b1;
                  state_d = StHigh;
               end
            end
            default:    state_d = StIdle;
         endcase
         // Rise wins over a coincident timeout, so the period ending here is still measured.
         if ((state_q != StIdle) && !rise && (cnt_q == TimeoutVal)) begin
            timeout_evt = 1'b1;
            state_d     = StWaitRise;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Cycle counter: restarts at 1 on each rise, saturates, and is held at 0 while idle.
   always_comb begin
      cnt_d = cnt_q;
      if (!active) begin
         cnt_d = 32'd0;
      end else if (rise) begin
         cnt_d = 32'd1;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Pending high time is latched on each fall and thrown away when measurement stops.
   always_comb begin
      hi_pend_d = hi_pend_q;
      if (!active) begin
         hi_pend_d = 32'd0;
      end else if (fall) begin
         hi_pend_d = cnt_q;
      end
   end

   // Counter and pending high-time registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= 32'd0;
         hi_pend_q <= 32'd0;
      end else begin
         cnt_q     <= cnt_d;
         hi_pend_q <= hi_pend_d;
      end
   end

   // Committed measurement: updated only when a full high/low cycle completes.
   always_comb begin
      high_time_d = high_time_q;
      period_d    = period_q;
      if (commit) begin
         high_time_d = hi_pend_q;
         period_d    = cnt_q;
      end
   end

   // Measurement result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         high_time_q <= 32'd0;
         period_q    <= 32'd0;
      end else begin
         high_time_q <= high_time_d;
         period_q    <= period_d;
      end
   end

   // Status bits: W1C first, then hardware set events so a coincident set wins.
   always_comb begin
      valid_d   = valid_q;
      timeout_d = timeout_q;
      overrun_d = overrun_q;
      if (wr_status) begin
         if (writedata[0]) valid_d   = 1'b0;
         if (writedata[1]) timeout_d = 1'b0;
         if (writedata[2]) overrun_d = 1'b0;
      end
      if (commit) begin
         valid_d = 1'b1;
         if (valid_q) overrun_d = 1'b1;
      end
      if (timeout_evt) begin
         timeout_d = 1'b1;
      end
   end

   // Control bits written directly from the bus.
   always_comb begin
      en_d     = en_q;
      irq_en_d = irq_en_q;
      if (wr_control) begin
         en_d     = writedata[0];
         irq_en_d = writedata[1];
      end
   end

   // Status, control and interrupt registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         en_q      <= 1'b0;
         irq_en_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
         en_q      <= en_d;
         irq_en_q  <= irq_en_d;
         irq_q     <= irq_en_q & (valid_q | timeout_q);
      end
   end

   assign irq = irq_q;

   // Zero-latency read mux; reads have no side effects.
   always_comb begin
      readdata = 32'd0;
      case (address)
         AddrHighTime: readdata = high_time_q;
         AddrPeriod:   readdata = period_q;
         AddrStatus:   readdata = {29'd0, overrun_q, timeout_q, valid_q};
         AddrControl:  readdata = {30'd0, irq_en_q, en_q};
         default:      readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_nios_security_duty_capture.sv
// Scoreboard bench for nios_security_duty_capture: stimulus pushes hand-computed
// expectations; a negedge monitor pops and compares whenever a sample is presented.
module tb_nios_security_duty_capture;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic        in_port;
   logic [31:0] readdata;
   logic        irq;

   nios_security_duty_capture #(
      .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .in_port   (in_port),
      .readdata  (readdata),
      .irq       (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic [31:0] exp_data;
      bit          chk_irq;
      logic        exp_irq;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   logic sample_req  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare on every presented sample.
   always @(negedge clk) begin
      if (sample_req) begin
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL monitor: sample presented with empty scoreboard");
         end else begin
            cur = sb.pop_front();
            vectors++;
            if (readdata !== cur.exp_data) begin
               miscompares++;
               $display("FAIL %s: readdata=0x%08h expected 0x%08h", cur.name, readdata,
                        cur.exp_data);
            end
            if (cur.chk_irq) begin
               vectors++;
               if (irq !== cur.exp_irq) begin
                  miscompares++;
                  $display("FAIL %s irq: irq=%b expected %b", cur.name, irq, cur.exp_irq);
               end
            end
         end
      end
   end

   // Advance to 1 time unit after the posedge that makes cyc == c.
   task automatic goto(input int c);
      if (cyc > c) begin
         miscompares++;
         $display("FAIL schedule: cycle %0d already passed (now %0d)", c, cyc);
      end
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_in(input int c, input logic v);
      goto(c);
      in_port = v;
   endtask

   task automatic wr(input int c, input logic [1:0] a, input logic [31:0] d);
      goto(c);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic readi(input int c, input logic [1:0] a, input logic [31:0] d,
                        input bit ci, input logic ei, input string n);
      exp_t e;
      goto(c);
      address    = a;
      chipselect = 1'b1;
      e.name     = n;
      e.exp_data = d;
      e.chk_irq  = ci;
      e.exp_irq  = ei;
      sb.push_back(e);
      sample_req = 1'b1;
      @(posedge clk);
      #1;
      sample_req = 1'b0;
      chipselect = 1'b0;
   endtask

   task automatic rd(input int c, input logic [1:0] a, input logic [31:0] d, input string n);
      readi(c, a, d, 1'b0, 1'b0, n);
   endtask

   int   t0, r1, r2, r3, r4, r5, r6, r7, r8, r9, c;
   exp_t er;

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      in_port    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset state
      readi(cyc, 2'd0, 32'd0, 1'b1, 1'b0, "rst_high_time");
      rd(cyc, 2'd1, 32'd0, "rst_period");
      rd(cyc, 2'd2, 32'd0, "rst_status");
      rd(cyc, 2'd3, 32'd0, "rst_control");

      // Enable and measure 300/700 for three periods
      t0 = cyc;
      wr(t0, 2'd3, 32'h1);
      rd(t0 + 2, 2'd3, 32'h1, "ctrl_en");
      r1 = t0 + 10;
      r2 = r1 + 1000;
      r3 = r1 + 2000;
      r4 = r1 + 3000;
      set_in(r1, 1'b1);
      set_in(r1 + 300, 1'b0);
      set_in(r2, 1'b1);
      readi(r2 + 5, 2'd0, 32'd300, 1'b1, 1'b0, "c1_high_time");
      rd(r2 + 6, 2'd1, 32'd1000, "c1_period");
      rd(r2 + 7, 2'd2, 32'h1, "c1_status");
      set_in(r2 + 300, 1'b0);
      set_in(r3, 1'b1);
      rd(r3 + 5, 2'd2, 32'h5, "c2_overrun");
      rd(r3 + 6, 2'd0, 32'd300, "c2_high_time");
      set_in(r3 + 300, 1'b0);

      // W1C of VALID on the commit edge: set wins
      set_in(r4, 1'b1);
      wr(r4 + 2, 2'd2, 32'h1);
      rd(r4 + 5, 2'd2, 32'h5, "w1c_vs_commit");
      wr(r4 + 6, 2'd2, 32'h1);
      rd(r4 + 8, 2'd2, 32'h4, "w1c_valid");
      wr(r4 + 9, 2'd2, 32'h4);
      rd(r4 + 11, 2'd2, 32'h0, "w1c_overrun");

      // Timeout 1000 cycles after the last rise detect, irq a cycle later
      wr(r4 + 12, 2'd3, 32'h3);
      set_in(r4 + 300, 1'b0);
      readi(r4 + 1002, 2'd2, 32'h0, 1'b1, 1'b0, "to_before");
      readi(r4 + 1003, 2'd2, 32'h2, 1'b1, 1'b0, "to_set");
      readi(r4 + 1004, 2'd2, 32'h2, 1'b1, 1'b1, "to_irq");
      rd(r4 + 1005, 2'd0, 32'd300, "to_high_hold");
      rd(r4 + 1006, 2'd1, 32'd1000, "to_period_hold");

      // After a timeout the first rise must not commit
      r5 = r4 + 1100;
      r6 = r5 + 900;
      r7 = r6 + 900;
      set_in(r5, 1'b1);
      readi(r5 + 5, 2'd2, 32'h2, 1'b1, 1'b1, "to_one_edge");
      wr(r5 + 6, 2'd2, 32'h2);
      readi(r5 + 8, 2'd2, 32'h0, 1'b1, 1'b0, "to_clear");
      set_in(r5 + 400, 1'b0);
      set_in(r6, 1'b1);
      readi(r6 + 5, 2'd0, 32'd400, 1'b1, 1'b1, "to_next_high");
      rd(r6 + 6, 2'd1, 32'd900, "to_next_period");
      rd(r6 + 7, 2'd2, 32'h1, "to_next_status");
      set_in(r6 + 400, 1'b0);

      // Disable mid-high, re-enable, then a 50/150 waveform
      set_in(r7, 1'b1);
      wr(r7 + 100, 2'd3, 32'h0);
      rd(r7 + 120, 2'd0, 32'd400, "dis_high_hold");
      rd(r7 + 121, 2'd1, 32'd900, "dis_period_hold");
      wr(r7 + 150, 2'd3, 32'h3);
      wr(r7 + 160, 2'd2, 32'h7);
      set_in(r7 + 400, 1'b0);
      r8 = r7 + 600;
      r9 = r8 + 200;
      set_in(r8, 1'b1);
      readi(r8 + 5, 2'd2, 32'h0, 1'b1, 1'b0, "reen_one_edge");
      set_in(r8 + 50, 1'b0);
      set_in(r9, 1'b1);
      readi(r9 + 5, 2'd0, 32'd50, 1'b1, 1'b1, "reen_high");
      rd(r9 + 6, 2'd1, 32'd200, "reen_period");
      rd(r9 + 7, 2'd2, 32'h1, "reen_status");
      set_in(r9 + 50, 1'b0);

      // Asynchronous reset mid-period: outputs clear before the next clk edge
      goto(r9 + 100);
      address    = 2'd1;
      chipselect = 1'b1;
      er.name     = "async_reset";
      er.exp_data = 32'd0;
      er.chk_irq  = 1'b1;
      er.exp_irq  = 1'b0;
      sb.push_back(er);
      sample_req = 1'b1;
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      sample_req = 1'b0;
      rd(cyc, 2'd0, 32'd0, "rst_hold_high");
      rd(cyc, 2'd2, 32'd0, "rst_hold_status");
      rd(cyc, 2'd3, 32'd0, "rst_hold_control");
      reset_n = 1'b1;

      // Stays idle after release until enabled
      c = cyc;
      set_in(c, 1'b1);
      set_in(c + 10, 1'b0);
      set_in(c + 30, 1'b1);
      set_in(c + 40, 1'b0);
      rd(c + 50, 2'd2, 32'd0, "idle_status");
      readi(c + 51, 2'd0, 32'd0, 1'b1, 1'b0, "idle_high");

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         miscompares += sb.size();
         $display("FAIL drain: %0d expectations never sampled, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
